lut_target_encoder: RTL

- Reverse side of the branch-target LUT: takes a 16-bit branch target and returns the LUT index that encodes it, plus a hit flag.
- Holds its own programmable copy of the target table, written through a simple write port, and scans it sequentially at one entry per cycle.
- Serves the program loader and debug path, which need target-to-index encoding, and uses a valid/ready request/response handshake.

---
 rtl/knips_pkg.sv | 20 ++
 rtl/lut_table_regs.sv | 43 ++++
 rtl/lut_target_encoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/knips_pkg.sv
// Shared definitions for the branch-target LUT pair: sizes, encoder FSM states and the
// power-on target table, kept here so the forward LUT and the encoder never drift apart.
package knips_pkg;

    localparam int LUT_DEPTH = 16;
    localparam int LUT_IDX_W = 4;
    localparam int TARGET_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } enc_state_t;

    localparam logic [TARGET_W-1:0] LUT_DEFAULTS [LUT_DEPTH] = '{
        16'd0,  16'd1,  16'd4,  16'd61, 16'd62, 16'd63, 16'd32, 16'd64,
        16'd255, 16'd0, 16'd0,  16'd0,  16'd0,  16'd0,  16'd0,  16'd0
    };

endpackage

// File: rtl/lut_table_regs.sv
// Target table register file: async reset to the shared defaults, write lands on the edge,
// read is combinational so a same-cycle compare always sees the pre-write value.
module lut_table_regs import knips_pkg::*; #(
    parameter int DEPTH  = LUT_DEPTH,
    parameter int IDX_W  = LUT_IDX_W,
    parameter int DATA_W = TARGET_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] entry_vec [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [DATA_W-1:0] rst_val;
        logic [DATA_W-1:0] entry_q;

        // Entries beyond the shared default table power up as zero.
        if (g < LUT_DEPTH) begin : g_def
            assign rst_val = DATA_W'(LUT_DEFAULTS[g]);
        end else begin : g_zero
            assign rst_val = '0;
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                entry_q <= rst_val;
            end else if (wr_en && (wr_addr == IDX_W'(g))) begin
                entry_q <= wr_data;
            end
        end

        assign entry_vec[g] = entry_q;
    end

    assign rd_data = entry_vec[rd_addr];

endmodule

// File: rtl/lut_target_encoder.sv
// Target-to-index encoder: linear scan, one entry per cycle; hit at k answers k+2 cycles after request, miss after DEPTH+1.
// Request side ready only in IDLE; the response is held stable until rsp_ready, with no combinational path back to req_ready.
module lut_target_encoder import knips_pkg::*; #(
    parameter int DEPTH  = LUT_DEPTH,
    parameter int IDX_W  = LUT_IDX_W,
    parameter int DATA_W = TARGET_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_target,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_idx
);

    enc_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic              hit_q, hit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] rd_data;
    logic              match;
    logic              last;

    lut_table_regs #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_table (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (ptr_q),
        .rd_data (rd_data)
    );

    assign match = (rd_data == target_q);
    assign last  = (ptr_q == IDX_W'(DEPTH - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            target_q <= '0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            target_q <= target_d;
            hit_q    <= hit_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        target_d = target_q;
        hit_d    = hit_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_target;
                    ptr_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                // First match wins, so duplicates resolve to the lowest index.
                if (match) begin
                    hit_d   = 1'b1;
                    idx_d   = ptr_q;
                    state_d = RESP;
                end else if (last) begin
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RESP;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_hit   = hit_q;
        rsp_idx   = idx_q;
    end

endmodule
